stream_mux_nto1: RTL and testbench

- Parametrised N-input to 1-output stream multiplexer with a valid/ready handshake on every port and a registered output stage.
- Generalises the 2:1 combinational mux to NUM_CH channels.
- Two channel-selection modes, chosen at runtime:
  - explicit select: the i_sel index picks the channel;
  - round-robin: fair arbitration across channels.
- Sits between multiple producer streams and a single downstream consumer.

---
 rtl/stream_mux_nto1.sv | 152 +++++++++++++++
 tb/tb_stream_mux_nto1.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1
//   N-input to 1-output valid/ready stream multiplexer with a registered
//   output stage. Channel selection is either explicit (i_sel) or
//   round-robin, chosen at runtime by i_mode.
//
// Optional feature (macro STREAM_MUX_PKT_LOCK_EN):
//   Adds i_last/o_last. A beat with i_last=0 locks the grant to its channel
//   until that channel delivers a beat with i_last=1.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_data           packed payloads, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_valid/o_ready  per-channel handshake (o_ready is one-hot or zero)
//   i_mode           0 = explicit select, 1 = round-robin
//   i_sel            channel index for explicit select
//   o_data/o_valid   registered output beat
//   o_ch             channel that sourced o_data
//   i_ready          downstream ready
//   i_last/o_last    packet boundary (STREAM_MUX_PKT_LOCK_EN only)
module stream_mux_nto1 #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]            i_valid,
  output logic [NUM_CH-1:0]            o_ready,
  input  logic                         i_mode,
  input  logic [SEL_WIDTH-1:0]         i_sel,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]            i_last,
  output logic                         o_last,
`endif
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_valid,
  output logic [SEL_WIDTH-1:0]         o_ch,
  input  logic                         i_ready
);

  logic                  load_en;
  logic                  xfer;
  logic                  grant_vld;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic                  base_vld;
  logic [SEL_WIDTH-1:0]  base_idx;
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [SEL_WIDTH-1:0]  rr_next;
  logic                  rr_adv;
  logic [31:0]           rr_idx;
  logic [DATA_WIDTH-1:0] grant_data;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic                  lock_q;
  logic [SEL_WIDTH-1:0]  lock_ch_q;
`endif

  assign load_en = !o_valid || i_ready;

  // Explicit or round-robin grant before any packet lock is applied.
  // The round-robin search runs from farthest to nearest so the last
  // assignment made is the first valid channel at or after rr_ptr.
  always_comb begin
    base_vld = 1'b0;
    base_idx = '0;
    rr_idx   = '0;
    if (!i_mode) begin
      if (32'(i_sel) < 32'(NUM_CH)) begin
        base_vld = i_valid[i_sel];
        base_idx = i_sel;
      end
    end else begin
      for (int j = NUM_CH - 1; j >= 0; j--) begin
        rr_idx = (32'(rr_ptr) + 32'(j)) % 32'(NUM_CH);
        if (i_valid[rr_idx[SEL_WIDTH-1:0]]) begin
          base_vld = 1'b1;
          base_idx = rr_idx[SEL_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_vld = base_vld;
    grant_idx = base_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      grant_vld = i_valid[lock_ch_q];
      grant_idx = lock_ch_q;
    end
`endif
  end

  // Reset also masks ready so no producer sees a handshake while held.
  assign xfer = i_rst_n && load_en && grant_vld;

  always_comb begin
    o_ready    = '0;
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == SEL_WIDTH'(k)) begin
        grant_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_ready[k] = xfer;
      end
    end
  end

  assign rr_next = (grant_idx == SEL_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

`ifdef STREAM_MUX_PKT_LOCK_EN
  // Inside a packet the pointer only moves once the packet closes.
  assign rr_adv = xfer && i_mode && i_last[grant_idx];
`else
  assign rr_adv = xfer && i_mode;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      rr_ptr  <= '0;
    end else begin
      if (load_en) begin
        o_valid <= grant_vld;
        if (grant_vld) begin
          o_data <= grant_data;
          o_ch   <= grant_idx;
        end
      end
      if (rr_adv) begin
        rr_ptr <= rr_next;
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      o_last    <= 1'b0;
    end else if (xfer) begin
      lock_q    <= !i_last[grant_idx];
      lock_ch_q <= grant_idx;
      o_last    <= i_last[grant_idx];
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_nto1.sv
module tb_stream_mux_nto1;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] ch;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NC*DW-1:0] i_data;
  logic [NC-1:0]    i_valid;
  logic [NC-1:0]    o_ready;
  logic             i_mode;
  logic [SW-1:0]    i_sel;
  logic [DW-1:0]    o_data;
  logic             o_valid;
  logic [SW-1:0]    o_ch;
  logic             i_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [NC-1:0]    i_last;
  logic             o_last;
`endif

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  stream_mux_nto1 #(.DATA_WIDTH(DW), .NUM_CH(NC), .SEL_WIDTH(SW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mode  (i_mode),
    .i_sel   (i_sel),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .i_last  (i_last),
    .o_last  (o_last),
`endif
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ch    (o_ch),
    .i_ready (i_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [SW-1:0] c, input logic l);
    beat_t b;
    b.data = d;
    b.ch   = c;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a beat is consumed when o_valid && i_ready at the edge.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got ch %0d data %0h, expected no beat", o_ch, o_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", 32'(o_data), 32'(e.data));
        chk("beat_ch", 32'(o_ch), 32'(e.ch));
`ifdef STREAM_MUX_PKT_LOCK_EN
        chk("beat_last", 32'(o_last), 32'(e.last));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] sparse_ch [3];
    sparse_ch[0] = 2'd3;
    sparse_ch[1] = 2'd0;
    sparse_ch[2] = 2'd3;

    rst_n   = 1'b0;
    i_valid = 4'hF;
    i_mode  = 1'b1;
    i_sel   = '0;
    i_ready = 1'b1;
    i_data  = 32'h1312_1110;
`ifdef STREAM_MUX_PKT_LOCK_EN
    i_last  = 4'hF;
`endif
    repeat (2) step();
    chk("rst_o_valid", 32'(o_valid), 32'h0);
    chk("rst_o_data", 32'(o_data), 32'h0);
    chk("rst_o_ch", 32'(o_ch), 32'h0);
    chk("rst_o_ready", 32'(o_ready), 32'h0);

    i_valid = '0;
    rst_n   = 1'b1;
    step();

    // Explicit select of channel 2
    i_mode  = 1'b0;
    i_sel   = 2'd2;
    i_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    i_valid = 4'b0100;
    #1;
    chk("sel_o_ready", 32'(o_ready), 32'h4);
    push(8'hA5, 2'd2, 1'b1);
    step();
    chk("sel_o_valid", 32'(o_valid), 32'h1);
    chk("sel_o_data", 32'(o_data), 32'hA5);
    chk("sel_o_ch", 32'(o_ch), 32'h2);
    i_sel = 2'd3;
    #1;
    chk("sel_invalid_ready", 32'(o_ready), 32'h0);
    step();
    chk("sel_invalid_o_valid", 32'(o_valid), 32'h0);

    // Round-robin with every channel valid, including wrap
    i_mode  = 1'b1;
    i_valid = 4'hF;
    i_data  = 32'h1312_1110;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_o_ready", 32'(o_ready), 32'(1 << (i % 4)));
      push(8'(16 + i % 4), 2'(i % 4), 1'b1);
      step();
    end

    // Backpressure holding beat 8'h11 from channel 1
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_o_ready", 32'(o_ready), 32'h0);
      chk("bp_o_data", 32'(o_data), 32'h11);
      chk("bp_o_ch", 32'(o_ch), 32'h1);
      chk("bp_o_valid", 32'(o_valid), 32'h1);
      step();
    end
    i_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(o_ready), 32'h4);
    push(8'h12, 2'd2, 1'b1);
    step();
    chk("bp_no_bubble_valid", 32'(o_valid), 32'h1);
    chk("bp_no_bubble_data", 32'(o_data), 32'h12);

    // Move pointer to 1, then sparse round-robin on channels 0 and 3
    i_valid = 4'b0001;
    #1;
    chk("sp_pre_ready", 32'(o_ready), 32'h1);
    push(8'h10, 2'd0, 1'b1);
    step();
    i_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sp_o_ready", 32'(o_ready), 32'(1 << sparse_ch[i]));
      push(8'(16 + 32'(sparse_ch[i])), sparse_ch[i], 1'b1);
      step();
    end
    i_valid = '0;
    repeat (2) step();
    chk("drain_o_valid", 32'(o_valid), 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    // Reset asserted while a beat is held
    i_ready = 1'b0;
    i_valid = 4'b0010;
    step();
    chk("mid_pre_o_valid", 32'(o_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_valid", 32'(o_valid), 32'h0);
    chk("mid_rst_o_data", 32'(o_data), 32'h0);
    i_valid = '0;
    step();
    rst_n   = 1'b1;
    i_ready = 1'b1;
    step();
    chk("post_rst_o_valid", 32'(o_valid), 32'h0);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Packet lock: ch1 sends three beats while ch2 waits
    i_mode  = 1'b1;
    i_valid = 4'b0001;
    i_last  = 4'hF;
    #1;
    chk("lk_pre_ready", 32'(o_ready), 32'h1);
    push(8'h10, 2'd0, 1'b1);
    step();
    i_valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      i_data = {8'h13, 8'h12, 8'(8'h21 + i), 8'h10};
      i_last = (i == 2) ? 4'b0110 : 4'b0100;
      #1;
      chk("lk_o_ready", 32'(o_ready), 32'h2);
      push(8'(8'h21 + i), 2'd1, (i == 2));
      step();
    end
    #1;
    chk("lk_release_ready", 32'(o_ready), 32'h4);
    push(8'h12, 2'd2, 1'b1);
    step();
    i_valid = '0;
    repeat (2) step();
    chk("lk_queue_empty", 32'(exp_q.size()), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
